// File: rtl/synth_bus_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : synth_bus_accum_if
// Purpose  : Sample-stream and published-bus bundle for synth_bus_accum.
//            The master side feeds the frame strobe, the sample stream and
//            the per-bus gain/mute controls. The slave side returns the
//            published buses and their status.
// Signals  : xxxx_zero    frame-boundary strobe, 1 cycle
//            sample_valid sample_in/sample_ch valid this cycle
//            sample_in    signed sample, SAMPLE_WIDTH
//            sample_ch    destination bus, CH_WIDTH
//            ch_gain      per-bus unsigned gain, bus c at [c*GAIN_WIDTH +: GAIN_WIDTH]
//            ch_mute      per-bus mute
//            bus_out      published buses, bus c at [c*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]
//            bus_valid    1-cycle pulse when bus_out updates
//            clip         per-bus saturation flag of the last published frame
//            overrun      sticky frame-overrun flag
// Revision : 1.0 - initial release
// ============================================================================
interface synth_bus_accum_if #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int OUT_CH        = 4,
  parameter int CH_WIDTH      = $clog2(OUT_CH),
  parameter int SAMPLE_WIDTH  = 17,
  parameter int GAIN_WIDTH    = 8
);
  logic                            xxxx_zero;
  logic                            sample_valid;
  logic [SAMPLE_WIDTH-1:0]         sample_in;
  logic [CH_WIDTH-1:0]             sample_ch;
  logic [OUT_CH*GAIN_WIDTH-1:0]    ch_gain;
  logic [OUT_CH-1:0]               ch_mute;
  logic [OUT_CH*AUD_BIT_DEPTH-1:0] bus_out;
  logic                            bus_valid;
  logic [OUT_CH-1:0]               clip;
  logic                            overrun;

  modport master (
    output xxxx_zero, sample_valid, sample_in, sample_ch, ch_gain, ch_mute,
    input  bus_out, bus_valid, clip, overrun
  );

  modport slave (
    input  xxxx_zero, sample_valid, sample_in, sample_ch, ch_gain, ch_mute,
    output bus_out, bus_valid, clip, overrun
  );
endinterface
`default_nettype wire

// File: rtl/synth_bus_accum.sv
`default_nettype none
// ============================================================================
// Module   : synth_bus_accum
// Purpose  : Multi-bus output accumulator. Sums a time-multiplexed stream of
//            signed oscillator samples into OUT_CH buses per frame, applies
//            per-bus gain and mute, saturates to AUD_BIT_DEPTH and publishes
//            all buses together once per frame (frames split by xxxx_zero).
// Ports    : AUDIO_CLK    sole clock, rising edge
//            reset_data_N asynchronous active-low reset
//            bus          synth_bus_accum_if.slave (stream in, buses out)
// Revision : 1.0 - initial release
// ============================================================================
module synth_bus_accum #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int VOICES        = 32,
  parameter int V_OSC         = 8,
  parameter int OUT_CH        = 4,
  parameter int CH_WIDTH      = $clog2(OUT_CH),
  parameter int SAMPLE_WIDTH  = 17,
  parameter int GAIN_WIDTH    = 8,
  parameter int ACC_W         = SAMPLE_WIDTH + $clog2(VOICES*V_OSC) + 1
) (
  input  wire                 AUDIO_CLK,
  input  wire                 reset_data_N,
  synth_bus_accum_if.slave    bus
);

  // Product of a full accumulator and a zero-extended gain always fits here.
  localparam int PW = ACC_W + GAIN_WIDTH + 1;
  localparam logic [CH_WIDTH-1:0] LAST_IDX = CH_WIDTH'(OUT_CH - 1);
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-AUD_BIT_DEPTH+1){1'b0}}, {(AUD_BIT_DEPTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-AUD_BIT_DEPTH+1){1'b1}}, {(AUD_BIT_DEPTH-1){1'b0}}};
  localparam logic [AUD_BIT_DEPTH-1:0] OUT_MAX = {1'b0, {(AUD_BIT_DEPTH-1){1'b1}}};
  localparam logic [AUD_BIT_DEPTH-1:0] OUT_MIN = {1'b1, {(AUD_BIT_DEPTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SCALE   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t                    state;
  logic [CH_WIDTH-1:0]       idx;
  logic                      act;            // active (accumulating) bank
  logic                      closed;
  logic                      tgt;            // bank receiving this cycle's sample
  logic                      zap;            // discard the interrupted closed bank

  logic signed [ACC_W-1:0]   acc     [2][OUT_CH];
  logic signed [ACC_W-1:0]   acc_nxt [2][OUT_CH];
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   nxt;

  logic signed [ACC_W-1:0]   sel_acc;
  logic [GAIN_WIDTH-1:0]     sel_gain;
  logic                      sel_mute;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      shifted;
  logic [AUD_BIT_DEPTH-1:0]  scaled;
  logic                      clip_bit;

  logic [AUD_BIT_DEPTH-1:0]  shadow [OUT_CH];
  logic [OUT_CH-1:0]         clip_next;
  logic [OUT_CH*AUD_BIT_DEPTH-1:0] pub_bus;
  logic [OUT_CH-1:0]         pub_clip;

  assign closed     = ~act;
  // A sample arriving with the frame strobe already belongs to the new frame,
  // i.e. to the bank that becomes active on this edge.
  assign tgt        = bus.xxxx_zero ? ~act : act;
  assign zap        = bus.xxxx_zero && (state != ACCUM);
  assign sample_ext = {{(ACC_W-SAMPLE_WIDTH){bus.sample_in[SAMPLE_WIDTH-1]}}, bus.sample_in};

  // --------------------------------------------------------------------------
  // Bank next-state: clear (scaled entry or whole interrupted bank), then add.
  // Channel compare over 0..OUT_CH-1 drops out-of-range sample_ch for free.
  // --------------------------------------------------------------------------
  always_comb begin
    nxt = '0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < OUT_CH; c++) begin
        nxt = acc[b][c];
        if ((1'(b) == closed) &&
            (zap || ((state == SCALE) && (idx == CH_WIDTH'(c))))) begin
          nxt = '0;
        end
        if (bus.sample_valid && (1'(b) == tgt) && (bus.sample_ch == CH_WIDTH'(c))) begin
          nxt = nxt + sample_ext;
        end
        acc_nxt[b][c] = nxt;
      end
    end
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_data_N) begin
    if (!reset_data_N) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < OUT_CH; c++) begin
          acc[b][c] <= '0;
        end
      end
    end else begin
      acc <= acc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Scaling datapath for the bus currently selected by idx.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_acc  = '0;
    sel_gain = '0;
    sel_mute = 1'b0;
    for (int c = 0; c < OUT_CH; c++) begin
      if (idx == CH_WIDTH'(c)) begin
        sel_acc  = acc[closed][c];
        sel_gain = bus.ch_gain[c*GAIN_WIDTH +: GAIN_WIDTH];
        sel_mute = bus.ch_mute[c];
      end
    end
  end

  assign prod    = PW'(sel_acc) * PW'($signed({1'b0, sel_gain}));
  assign shifted = prod >>> (GAIN_WIDTH - 1);

  always_comb begin
    scaled   = shifted[AUD_BIT_DEPTH-1:0];
    clip_bit = 1'b0;
    if (sel_mute) begin
      scaled   = '0;
      clip_bit = 1'b0;
    end else if (shifted > SAT_MAX) begin
      scaled   = OUT_MAX;
      clip_bit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      scaled   = OUT_MIN;
      clip_bit = 1'b1;
    end
  end

  // The last bus is merged straight into the published word so bus_valid can
  // rise the cycle after the final scale step.
  always_comb begin
    pub_bus  = '0;
    pub_clip = '0;
    for (int c = 0; c < OUT_CH; c++) begin
      pub_bus[c*AUD_BIT_DEPTH +: AUD_BIT_DEPTH] = (idx == CH_WIDTH'(c)) ? scaled : shadow[c];
      pub_clip[c] = (idx == CH_WIDTH'(c)) ? clip_bit : clip_next[c];
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM and registered outputs. The frame strobe has priority in every
  // state; outside ACCUM it aborts the frame in flight (overrun).
  // --------------------------------------------------------------------------
  always_ff @(posedge AUDIO_CLK or negedge reset_data_N) begin
    if (!reset_data_N) begin
      state         <= ACCUM;
      idx           <= '0;
      act           <= 1'b0;
      clip_next     <= '0;
      for (int c = 0; c < OUT_CH; c++) begin
        shadow[c] <= '0;
      end
      bus.bus_out   <= '0;
      bus.bus_valid <= 1'b0;
      bus.clip      <= '0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.bus_valid <= 1'b0;
      if (bus.xxxx_zero) begin
        act   <= ~act;
        idx   <= '0;
        state <= SCALE;
        if (state != ACCUM) begin
          bus.overrun <= 1'b1;
        end
      end else begin
        case (state)
          SCALE: begin
            for (int c = 0; c < OUT_CH; c++) begin
              if (idx == CH_WIDTH'(c)) begin
                shadow[c]    <= scaled;
                clip_next[c] <= clip_bit;
              end
            end
            if (idx == LAST_IDX) begin
              bus.bus_out   <= pub_bus;
              bus.clip      <= pub_clip;
              bus.bus_valid <= 1'b1;
              state         <= PUBLISH;
            end else begin
              idx <= idx + CH_WIDTH'(1);
            end
          end
          PUBLISH: state <= ACCUM;
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synth_bus_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_synth_bus_accum
// Purpose  : Self-checking bench for synth_bus_accum. Expected publications
//            are queued when a frame closes and compared by a monitor when
//            bus_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synth_bus_accum;
  localparam int AUD = 24;
  localparam int OUT_CH = 5;
  localparam int CHW = 3;
  localparam int SW = 17;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  synth_bus_accum_if #(.AUD_BIT_DEPTH(AUD), .OUT_CH(OUT_CH), .CH_WIDTH(CHW),
                       .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW)) bus_if ();

  synth_bus_accum #(.AUD_BIT_DEPTH(AUD), .VOICES(32), .V_OSC(8), .OUT_CH(OUT_CH),
                    .CH_WIDTH(CHW), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW)) dut (
    .AUDIO_CLK    (clk),
    .reset_data_N (rst_n),
    .bus          (bus_if.slave)
  );

  typedef struct {
    int                    edge_no;
    logic [OUT_CH*AUD-1:0] bus;
    logic [OUT_CH-1:0]     clip;
  } exp_t;

  exp_t  sb[$];
  longint sums[OUT_CH];
  int    gain_m[OUT_CH];
  bit    mute_m[OUT_CH];
  int    last_zero = -1000;
  bit    ovr_model = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t scale_frame(input int edge_no);
    exp_t   e;
    longint maxv = (longint'(1) << (AUD-1)) - 1;
    longint minv = -(longint'(1) << (AUD-1));
    longint s;
    e.edge_no = edge_no;
    e.bus = '0;
    e.clip = '0;
    for (int c = 0; c < OUT_CH; c++) begin
      s = (sums[c] * gain_m[c]) >>> (GW-1);
      if (s > maxv) begin s = maxv; e.clip[c] = 1'b1; end
      else if (s < minv) begin s = minv; e.clip[c] = 1'b1; end
      if (mute_m[c]) begin s = 0; e.clip[c] = 1'b0; end
      e.bus[c*AUD +: AUD] = s[AUD-1:0];
    end
    return e;
  endfunction

  task automatic apply_ctrl();
    for (int c = 0; c < OUT_CH; c++) begin
      bus_if.ch_gain[c*GW +: GW] = gain_m[c][GW-1:0];
      bus_if.ch_mute[c] = mute_m[c];
    end
  endtask

  // One clock: drive inputs, advance the reference model at the edge.
  task automatic step(input bit zero, input bit valid, input int smp, input int ch);
    bus_if.xxxx_zero    = zero;
    bus_if.sample_valid = valid;
    bus_if.sample_in    = smp[SW-1:0];
    bus_if.sample_ch    = ch[CHW-1:0];
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (zero) begin
        if (cyc - last_zero <= OUT_CH + 1) begin
          ovr_model = 1'b1;
          if (cyc - last_zero <= OUT_CH && sb.size() > 0) void'(sb.pop_back());
        end
        sb.push_back(scale_frame(cyc + OUT_CH));
        for (int c = 0; c < OUT_CH; c++) sums[c] = 0;
        last_zero = cyc;
      end
      if (valid && ch < OUT_CH) sums[ch] += smp;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic model_reset();
    sb.delete();
    for (int c = 0; c < OUT_CH; c++) sums[c] = 0;
    ovr_model = 1'b0;
    last_zero = -1000;
  endtask

  function automatic longint bus_s(input int c);
    logic signed [AUD-1:0] v;
    v = bus_if.bus_out[c*AUD +: AUD];
    return longint'(v);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus_if.bus_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_bus_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_edge", cyc, e.edge_no);
        for (int c = 0; c < OUT_CH; c++)
          chk($sformatf("bus%0d", c), bus_if.bus_out[c*AUD +: AUD], e.bus[c*AUD +: AUD]);
        chk("clip", bus_if.clip, e.clip);
        chk("overrun", bus_if.overrun, ovr_model);
      end
    end
  end

  initial begin
    for (int c = 0; c < OUT_CH; c++) begin gain_m[c] = 128; mute_m[c] = 1'b0; sums[c] = 0; end
    apply_ctrl();
    bus_if.xxxx_zero = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.sample_in = '0;
    bus_if.sample_ch = '0;

    // 1. Reset, including reset asserted mid-frame and mid-scale
    idle(3);
    chk("rst_bus_out", bus_if.bus_out, 0);
    chk("rst_bus_valid", bus_if.bus_valid, 0);
    rst_n = 1'b1;
    step(0, 1, 1234, 0);
    step(0, 1, 777, 2);
    step(1, 1, 50, 1);
    idle(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_bus_out", bus_if.bus_out, 0);
    chk("rst_mid_bus_valid", bus_if.bus_valid, 0);
    chk("rst_mid_clip", bus_if.clip, 0);
    chk("rst_mid_overrun", bus_if.overrun, 0);
    idle(OUT_CH + 3);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("post_rst_bus0", bus_s(0), 0);

    // 2. Basic sums
    step(0, 1, 1000, 0);
    step(0, 1, 2000, 0);
    step(0, 1, -3, 1);
    step(0, 1, -500, 0);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("sum_bus0", bus_s(0), 2500);
    chk("sum_bus1_raw", bus_if.bus_out[AUD +: AUD], 24'hFFFFFD);
    chk("sum_clip", bus_if.clip, 0);

    // 3. Saturation both ways, then an empty frame clears the flag
    gain_m[2] = 255; apply_ctrl();
    for (int i = 0; i < 256; i++) step(0, 1, 65535, 2);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("sat_hi_bus2", bus_if.bus_out[2*AUD +: AUD], 24'h7FFFFF);
    chk("sat_hi_clip2", bus_if.clip[2], 1);
    for (int i = 0; i < 256; i++) step(0, 1, -65536, 2);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("sat_lo_bus2", bus_if.bus_out[2*AUD +: AUD], 24'h800000);
    chk("sat_lo_clip2", bus_if.clip[2], 1);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("sat_clear_clip2", bus_if.clip[2], 0);
    gain_m[2] = 128; apply_ctrl();

    // 4. Gain and mute
    gain_m[1] = 64; apply_ctrl();
    step(0, 1, 1001, 1);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("gain_bus1", bus_s(1), 500);
    gain_m[1] = 128; mute_m[1] = 1'b1; apply_ctrl();
    step(0, 1, 32767, 1);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("mute_bus1", bus_s(1), 0);
    chk("mute_clip1", bus_if.clip[1], 0);
    mute_m[1] = 1'b0; apply_ctrl();

    // 5. Boundary: sample with the strobe goes to the next frame; bad channels ignored
    step(1, 1, 7, 0);
    idle(OUT_CH + 3);
    chk("bnd_cur_bus0", bus_s(0), 0);
    step(0, 1, 99, 5);
    step(0, 1, 55, 7);
    step(1, 0, 0, 0);
    idle(OUT_CH + 3);
    chk("bnd_next_bus0", bus_s(0), 7);
    chk("bnd_ignored_bus1", bus_s(1), 0);
    chk("bnd_ignored_bus3", bus_s(3), 0);

    // 6. Overrun: second strobe three cycles after the first
    step(0, 1, 100, 0);
    step(1, 0, 0, 0);
    step(0, 1, 11, 0);
    step(0, 1, 22, 3);
    step(1, 1, 5, 1);
    idle(OUT_CH + 3);
    chk("ovr_flag", bus_if.overrun, 1);
    chk("ovr_bus0", bus_s(0), 11);
    chk("ovr_bus3", bus_s(3), 22);

    // Randomised frames with random gains/mutes held through each scale
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(OUT_CH + 2, OUT_CH + 24));
      for (int i = 0; i < len - 1; i++)
        step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 131071)) - 65536,
             int'($urandom_range(0, 7)));
      for (int c = 0; c < OUT_CH; c++) begin
        gain_m[c] = int'($urandom_range(0, 255));
        mute_m[c] = ($urandom_range(0, 7) == 0);
      end
      apply_ctrl();
      step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 131071)) - 65536,
           int'($urandom_range(0, 7)));
    end
    idle(OUT_CH + 6);
    chk("drain_queue_empty", sb.size(), 0);

    // Reset clears the sticky overrun
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("final_rst_overrun", bus_if.overrun, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
